// File: rtl/mdu_pkg.sv
// Definitions shared by the MDU and its request issuer: operation encoding,
// the operation driven while nothing is being issued, and operation classifiers.
package mdu_pkg;

    localparam int INT_WIDTH = 32;
    typedef logic [INT_WIDTH-1:0] int_t;

    typedef enum logic [2:0] {
        MDU_READ_HI            = 3'd0,
        MDU_READ_LO            = 3'd1,
        MDU_WRITE_HI           = 3'd2,
        MDU_WRITE_LO           = 3'd3,
        MDU_START_SIGNED_MUL   = 3'd4,
        MDU_START_UNSIGNED_MUL = 3'd5,
        MDU_START_SIGNED_DIV   = 3'd6,
        MDU_START_UNSIGNED_DIV = 3'd7
    } mdu_operation_t;

    // The MDU writes HI/LO on the operation code alone, so the resting drive
    // has to be a harmless read.
    localparam mdu_operation_t MDU_IDLE_OPERATION = MDU_READ_HI;

    function automatic logic isMduStart(input mdu_operation_t op);
        return op inside {MDU_START_SIGNED_MUL, MDU_START_UNSIGNED_MUL,
                          MDU_START_SIGNED_DIV, MDU_START_UNSIGNED_DIV};
    endfunction

    function automatic logic isMduRead(input mdu_operation_t op);
        return op inside {MDU_READ_HI, MDU_READ_LO};
    endfunction

endpackage

// File: rtl/mdu_busy_watchdog.sv
// Counts consecutive busy cycles of a held request and raises a sticky flag
// once the MDU has been busy for TIMEOUT_CYCLES in a row.
module mdu_busy_watchdog #(
    parameter int TIMEOUT_CYCLES   = 16,
    parameter int BUSY_COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic counting,
    output logic timeoutError
);

    localparam logic [BUSY_COUNT_WIDTH-1:0] LIMIT = BUSY_COUNT_WIDTH'(TIMEOUT_CYCLES);

    logic [BUSY_COUNT_WIDTH-1:0] busy_cycles;

    // Saturating busy counter; the flag sets on the edge the count reaches LIMIT.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            busy_cycles  <= '0;
            timeoutError <= 1'b0;
        end else begin
            if (!counting) begin
                busy_cycles <= '0;
            end else if (busy_cycles != LIMIT) begin
                busy_cycles <= busy_cycles + 1'b1;
            end
            if (counting && (busy_cycles >= LIMIT - 1'b1)) begin
                timeoutError <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_request_issuer.sv
// Execute-stage front end of the MDU: a one-entry issue register that drives
// the MDU only when it is free, captures HI/LO reads, and stalls the pipeline
// while a new request cannot be taken.
module mdu_request_issuer
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 16,
    parameter int BUSY_COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  mdu_operation_t        reqOperation,
    input  logic [DATA_WIDTH-1:0] reqOperand1,
    input  logic [DATA_WIDTH-1:0] reqOperand2,
    input  logic                  flush,
    output logic                  stall,
    output logic                  resultValid,
    output logic [DATA_WIDTH-1:0] resultData,
    output logic [DATA_WIDTH-1:0] mduOperand1,
    output logic [DATA_WIDTH-1:0] mduOperand2,
    output mdu_operation_t        mduOperation,
    output logic                  mduStart,
    input  logic                  mduBusy,
    input  logic [DATA_WIDTH-1:0] mduDataRead,
    output logic                  timeoutError
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state;
    mdu_operation_t        saved_op;
    logic [DATA_WIDTH-1:0] saved_operand1;
    logic [DATA_WIDTH-1:0] saved_operand2;
    logic                  driving;
    logic                  completing;

    // MDU drive and handshake: the held request only reaches the MDU in ISSUE
    // without flush; start additionally waits for the MDU to be free.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave one unassigned and infer a latch.
        driving      = (state == ISSUE) && !flush;
        completing   = driving && !mduBusy;
        reqReady     = (state == IDLE) || completing;
        mduOperation = MDU_IDLE_OPERATION;
        mduOperand1  = '0;
        mduOperand2  = '0;
        mduStart     = 1'b0;
        if (driving) begin
            mduOperation = saved_op;
            mduOperand1  = saved_operand1;
            mduOperand2  = saved_operand2;
            mduStart     = !mduBusy && isMduStart(saved_op);
        end
    end

    assign stall = reqValid && !reqReady;

    // Issue register, state and read-result capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            saved_op       <= MDU_IDLE_OPERATION;
            saved_operand1 <= '0;
            saved_operand2 <= '0;
            resultValid    <= 1'b0;
            resultData     <= '0;
        end else begin
            resultValid <= 1'b0;
            if (completing && isMduRead(saved_op)) begin
                resultData  <= mduDataRead;
                resultValid <= 1'b1;
            end
            if (reqValid && reqReady) begin
                saved_op       <= reqOperation;
                saved_operand1 <= reqOperand1;
                saved_operand2 <= reqOperand2;
                state          <= ISSUE;
            end else if ((state == ISSUE) && (flush || !mduBusy)) begin
                state <= IDLE;
            end
        end
    end

    mdu_busy_watchdog #(
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES),
        .BUSY_COUNT_WIDTH (BUSY_COUNT_WIDTH)
    ) u_watchdog (
        .clock        (clock),
        .reset        (reset),
        .counting     ((state == ISSUE) && mduBusy),
        .timeoutError (timeoutError)
    );

endmodule

// File: tb/tb_mdu_request_issuer.sv
// Bench for mdu_request_issuer: an MDU stub with real latencies, a queue-based
// reference model checked every cycle, a vector table, directed sequences and
// random traffic.
module tb_mdu_request_issuer;
    import mdu_pkg::*;

    localparam int TIMEOUT = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           reqValid = 1'b0;
    logic           reqReady;
    mdu_operation_t reqOperation = MDU_READ_HI;
    logic [31:0]    reqOperand1 = '0;
    logic [31:0]    reqOperand2 = '0;
    logic           flush = 1'b0;
    logic           stall;
    logic           resultValid;
    logic [31:0]    resultData;
    logic [31:0]    mduOperand1;
    logic [31:0]    mduOperand2;
    mdu_operation_t mduOperation;
    logic           mduStart;
    logic           mduBusy;
    logic [31:0]    mduDataRead;
    logic           timeoutError;

    mdu_request_issuer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .reqOperation(reqOperation), .reqOperand1(reqOperand1), .reqOperand2(reqOperand2),
        .flush(flush), .stall(stall), .resultValid(resultValid), .resultData(resultData),
        .mduOperand1(mduOperand1), .mduOperand2(mduOperand2), .mduOperation(mduOperation),
        .mduStart(mduStart), .mduBusy(mduBusy), .mduDataRead(mduDataRead),
        .timeoutError(timeoutError)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- MDU stub ----------------
    logic [31:0] hi_q, lo_q;
    logic [63:0] pend_q;
    int          busy_cnt;
    bit          force_busy = 0;

    function automatic logic [63:0] mdu_compute(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = $signed(a); sb = $signed(b); ua = 64'(a); ub = 64'(b);
        r = '0;
        case (op)
            MDU_START_SIGNED_MUL:   r = 64'(sa * sb);
            MDU_START_UNSIGNED_MUL: r = ua * ub;
            MDU_START_SIGNED_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            MDU_START_UNSIGNED_DIV: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default:                r = '0;
        endcase
        return r;
    endfunction

    function automatic bit tb_is_start(input mdu_operation_t op);
        return op == MDU_START_SIGNED_MUL || op == MDU_START_UNSIGNED_MUL ||
               op == MDU_START_SIGNED_DIV || op == MDU_START_UNSIGNED_DIV;
    endfunction

    function automatic bit tb_is_read(input mdu_operation_t op);
        return op == MDU_READ_HI || op == MDU_READ_LO;
    endfunction

    assign mduBusy     = (busy_cnt != 0) || force_busy;
    assign mduDataRead = (mduOperation == MDU_READ_LO) ? lo_q : hi_q;

    // Multiply: 5 busy cycles, divide: 10; HI/LO commit one cycle before busy falls.
    always @(posedge clock) begin
        if (!reset) begin
            busy_cnt <= 0; hi_q <= '0; lo_q <= '0; pend_q <= '0;
        end else if (mduBusy) begin
            if (busy_cnt == 2) begin hi_q <= pend_q[63:32]; lo_q <= pend_q[31:0]; end
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end else if (mduStart) begin
            pend_q   <= mdu_compute(mduOperation, mduOperand1, mduOperand2);
            busy_cnt <= (mduOperation == MDU_START_SIGNED_MUL || mduOperation == MDU_START_UNSIGNED_MUL) ? 5 : 10;
        end else if (mduOperation == MDU_WRITE_HI) begin
            hi_q <= mduOperand1;
        end else if (mduOperation == MDU_WRITE_LO) begin
            lo_q <= mduOperand1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct { mdu_operation_t op; logic [31:0] a; logic [31:0] b; } req_t;
    req_t        mdl_q[$];
    bit          mdl_rv;
    logic [31:0] mdl_rd;
    bit          mdl_tmo;
    int          mdl_run;
    bit          last_accept;

    // Observations sampled before the edge of the most recent step.
    logic        obs_ready, obs_stall, obs_start, obs_rv, obs_tmo;
    logic [31:0] obs_rd, obs_o1;
    mdu_operation_t obs_mop;
    int          starts_seen, stalls_seen;
    logic [31:0] results[$];

    task automatic model_clear();
        mdl_q.delete(); mdl_rv = 0; mdl_rd = '0; mdl_tmo = 0; mdl_run = 0;
    endtask

    task automatic step(input logic rv, input mdu_operation_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
        bit pending, busy, drv, complete, e_ready;
        req_t r;
        reqValid = rv; reqOperation = op; reqOperand1 = a; reqOperand2 = b; flush = fl;
        #2;
        pending  = mdl_q.size() != 0;
        busy     = (busy_cnt != 0) || force_busy;
        drv      = pending && !fl;
        complete = drv && !busy;
        e_ready  = !pending || complete;
        check("reqReady", 32'(reqReady), 32'(e_ready));
        check("stall", 32'(stall), 32'(rv && !e_ready));
        check("mduStart", 32'(mduStart), 32'(complete && tb_is_start(mdl_q[0].op)));
        check("mduOperation", 32'(mduOperation), drv ? 32'(mdl_q[0].op) : 32'(MDU_READ_HI));
        check("mduOperand1", mduOperand1, drv ? mdl_q[0].a : 32'h0);
        check("mduOperand2", mduOperand2, drv ? mdl_q[0].b : 32'h0);
        check("resultValid", 32'(resultValid), 32'(mdl_rv));
        check("resultData", resultData, mdl_rd);
        check("timeoutError", 32'(timeoutError), 32'(mdl_tmo));
        obs_ready = reqReady; obs_stall = stall; obs_start = mduStart; obs_rv = resultValid;
        obs_tmo = timeoutError; obs_rd = resultData; obs_o1 = mduOperand1; obs_mop = mduOperation;
        if (mduStart) starts_seen++;
        if (stall) stalls_seen++;
        if (resultValid) results.push_back(resultData);
        // advance the model across the edge
        mdl_rv = complete && tb_is_read(mdl_q[0].op);
        if (mdl_rv) mdl_rd = (mdl_q[0].op == MDU_READ_LO) ? lo_q : hi_q;
        mdl_run = (pending && busy) ? ((mdl_run < TIMEOUT) ? mdl_run + 1 : TIMEOUT) : 0;
        if (mdl_run == TIMEOUT) mdl_tmo = 1;
        if (pending && (fl || !busy)) void'(mdl_q.pop_front());
        last_accept = rv && e_ready;
        if (last_accept) begin r.op = op; r.a = a; r.b = b; mdl_q.push_back(r); end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, MDU_READ_HI, 32'h0, 32'h0, 0);
    endtask

    task automatic issue(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(1, op, a, b, 0);
            done = last_accept;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL issue_timeout op=%0d not accepted in 60 cycles", op); end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mdl_q.size() != 0 || busy_cnt != 0 || mdl_rv) && n < 60) begin
            idle(1); n++;
        end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL drain_timeout cycles=%0d limit=60", n); end
    endtask

    task automatic do_reset(input int n, input logic rv);
        reset = 1'b0; reqValid = rv; reqOperation = MDU_START_SIGNED_MUL; flush = 0; force_busy = 0;
        repeat (n) @(posedge clock);
        #1 reset = 1'b1;
        model_clear();
    endtask

    task automatic clear_tally();
        starts_seen = 0; stalls_seen = 0; results.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rv; mdu_operation_t op; logic [31:0] a; logic fl;
        logic e_ready; logic e_stall; mdu_operation_t e_mop; logic [31:0] e_o1;
        logic e_rv; logic [31:0] e_rd;
    } vec_t;
    vec_t vecs[12];

    initial begin
        // pipelined reads after WRITE_LO 5, flush in IDLE, flushed write, read-back
        vecs[0]  = '{1, MDU_WRITE_LO, 32'd5,          0, 1, 0, MDU_READ_HI,  32'd0,          0, 32'd0};
        vecs[1]  = '{1, MDU_READ_LO,  32'd0,          0, 1, 0, MDU_WRITE_LO, 32'd5,          0, 32'd0};
        vecs[2]  = '{1, MDU_READ_LO,  32'd0,          0, 1, 0, MDU_READ_LO,  32'd0,          0, 32'd0};
        vecs[3]  = '{1, MDU_READ_LO,  32'd0,          0, 1, 0, MDU_READ_LO,  32'd0,          1, 32'd5};
        vecs[4]  = '{0, MDU_READ_HI,  32'd0,          0, 1, 0, MDU_READ_LO,  32'd0,          1, 32'd5};
        vecs[5]  = '{0, MDU_READ_HI,  32'd0,          0, 1, 0, MDU_READ_HI,  32'd0,          1, 32'd5};
        vecs[6]  = '{0, MDU_READ_HI,  32'd0,          1, 1, 0, MDU_READ_HI,  32'd0,          0, 32'd5};
        vecs[7]  = '{1, MDU_WRITE_HI, 32'h1234_5678,  1, 1, 0, MDU_READ_HI,  32'd0,          0, 32'd5};
        vecs[8]  = '{0, MDU_READ_HI,  32'd0,          1, 0, 0, MDU_READ_HI,  32'd0,          0, 32'd5};
        vecs[9]  = '{1, MDU_READ_HI,  32'd0,          0, 1, 0, MDU_READ_HI,  32'd0,          0, 32'd5};
        vecs[10] = '{0, MDU_READ_HI,  32'd0,          0, 1, 0, MDU_READ_HI,  32'd0,          0, 32'd5};
        vecs[11] = '{0, MDU_READ_HI,  32'd0,          0, 1, 0, MDU_READ_HI,  32'd0,          1, 32'd0};
    end

    initial begin
        model_clear();
        clear_tally();

        // Reset with a request pending: nothing latched, idle drive.
        do_reset(2, 1'b1);
        #2;
        check("rst_reqReady", 32'(reqReady), 32'd1);
        check("rst_mduOperation", 32'(mduOperation), 32'(MDU_READ_HI));
        check("rst_mduStart", 32'(mduStart), 32'd0);
        check("rst_resultValid", 32'(resultValid), 32'd0);
        check("rst_timeoutError", 32'(timeoutError), 32'd0);
        @(posedge clock); #1;
        do_reset(1, 1'b0);

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rv, vecs[i].op, vecs[i].a, 32'h0, vecs[i].fl);
            check($sformatf("vec%0d_ready", i), 32'(obs_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d_stall", i), 32'(obs_stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d_mop", i), 32'(obs_mop), 32'(vecs[i].e_mop));
            check($sformatf("vec%0d_o1", i), obs_o1, vecs[i].e_o1);
            check($sformatf("vec%0d_rv", i), 32'(obs_rv), 32'(vecs[i].e_rv));
            check($sformatf("vec%0d_rd", i), obs_rd, vecs[i].e_rd);
        end
        do_reset(1, 1'b0);

        // Signed multiply then back-to-back reads.
        clear_tally();
        issue(MDU_START_SIGNED_MUL, 32'd7, 32'hFFFF_FFFD);
        issue(MDU_READ_LO, 32'h0, 32'h0);
        issue(MDU_READ_HI, 32'h0, 32'h0);
        drain();
        check("mul_starts", 32'(starts_seen), 32'd1);
        check("mul_stalls", 32'(stalls_seen), 32'd5);
        check("mul_nresults", 32'(results.size()), 32'd2);
        if (results.size() == 2) begin
            check("mul_lo", results[0], 32'hFFFF_FFEB);
            check("mul_hi", results[1], 32'hFFFF_FFFF);
        end

        // Write to HI while a divide runs: the write waits and wins.
        clear_tally();
        issue(MDU_START_UNSIGNED_DIV, 32'd100, 32'd7);
        issue(MDU_WRITE_HI, 32'h1234_5678, 32'h0);
        issue(MDU_READ_HI, 32'h0, 32'h0);
        issue(MDU_READ_LO, 32'h0, 32'h0);
        drain();
        check("div_write_wait", 32'(stalls_seen), 32'd10);
        check("div_nresults", 32'(results.size()), 32'd2);
        if (results.size() == 2) begin
            check("div_hi_written", results[0], 32'h1234_5678);
            check("div_lo_quot", results[1], 32'd14);
        end

        // Flush on the second busy cycle drops the held read.
        clear_tally();
        issue(MDU_START_SIGNED_DIV, 32'hFFFF_FF00, 32'd3);
        issue(MDU_READ_LO, 32'h0, 32'h0);
        idle(1);
        step(0, MDU_READ_HI, 32'h0, 32'h0, 1);
        idle(1);
        check("flush_idle_ready", 32'(obs_ready), 32'd1);
        check("flush_idle_busy", 32'(busy_cnt != 0), 32'd1);
        check("flush_mop", 32'(obs_mop), 32'(MDU_READ_HI));
        drain();
        check("flush_no_result", 32'(results.size()), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, mdu_operation_t'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom,
                 $urandom_range(0, 19) == 0);
        end
        drain();

        // Watchdog: stuck-busy MDU with a held write.
        do_reset(1, 1'b0);
        force_busy = 1;
        issue(MDU_WRITE_HI, 32'hCAFE_0001, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) idle(1);
        check("wd_before", 32'(obs_tmo), 32'd0);
        idle(1);
        check("wd_set", 32'(obs_tmo), 32'd1);
        force_busy = 0;
        idle(3);
        check("wd_sticky", 32'(obs_tmo), 32'd1);

        // Reset mid-operation abandons the held read.
        clear_tally();
        force_busy = 1;
        issue(MDU_READ_HI, 32'h0, 32'h0);
        idle(2);
        do_reset(1, 1'b0);
        idle(5);
        check("midrst_no_result", 32'(results.size()), 32'd0);
        check("midrst_tmo_clear", 32'(obs_tmo), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "bench time limit");
    end

endmodule
